// File: rtl/mac_check.sv
// Receive-side MAC checker: recomputes the rotate/XOR MAC over a message
// arriving one N-bit chunk per handshake, then compares it with the MAC
// delivered alongside the message and reports match or mismatch.
module mac_check #(
  parameter int N          = 8,
  parameter int MAX_CHUNKS = 16,
  parameter int CNT_W      = $clog2(MAX_CHUNKS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     key,
  input  logic [N-1:0]     data,
  input  logic             data_valid,
  input  logic             last,
  input  logic [N-1:0]     rx_mac,
  input  logic             mac_valid,
  output logic             ready,
  output logic             done,
  output logic             match,
  output logic             err,
  output logic [CNT_W-1:0] chunk_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCUM    = 2'd1,
    S_WAIT_MAC = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHUNKS);

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic             err_q, err_d;

  logic             accept;
  logic [N-1:0]     acc_step;
  logic [CNT_W-1:0] cnt_step;

  // Accumulator and count values that an accepted chunk would produce; the
  // first chunk of a message uses the live key, later ones the latched key.
  always_comb begin
    accept = data_valid && ready;
    if (state_q == S_IDLE) begin
      acc_step = key ^ data;
      cnt_step = CNT_W'(1);
    end else begin
      acc_step = {acc_q[N-2:0], acc_q[N-1]} ^ (key_q ^ data);
      cnt_step = cnt_q + CNT_W'(1);
    end
  end

  // Next-state logic: chunk accumulation, MAC comparison and error pulses.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          acc_d = acc_step;
          cnt_d = cnt_step;
          if (state_q == S_IDLE) key_d = key;
          if (last) begin
            if (mac_valid) begin
              // Last chunk and MAC together: compare against the final value.
              match_d = (rx_mac == acc_step);
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_MAC;
            end
          end else if (cnt_step == MAX_CNT) begin
            // Message too long: abandon it without a comparison.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ACCUM;
          end
        end
        // A MAC that does not arrive with the final chunk is a protocol error.
        if (mac_valid && !(accept && last)) err_d = 1'b1;
      end
      S_WAIT_MAC: begin
        if (mac_valid) begin
          match_d = (rx_mac == acc_q);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  // Output mapping.
  always_comb begin
    ready       = (state_q != S_WAIT_MAC);
    busy        = (state_q != S_IDLE);
    done        = done_q;
    match       = match_q;
    err         = err_q;
    chunk_count = cnt_q;
  end

endmodule

// File: tb/tb_mac_check.sv
// Self-checking bench for mac_check: directed vector table, hand-written
// reset sequence, then randomized traffic against a message-level model.
module tb_mac_check;

  localparam int N          = 8;
  localparam int MAX_CHUNKS = 4;
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     key, data, rx_mac;
  logic             data_valid, last, mac_valid;
  logic             ready, done, match, err, busy;
  logic [CNT_W-1:0] chunk_count;

  int n_applied = 0;
  int n_miss    = 0;

  mac_check #(.N(N), .MAX_CHUNKS(MAX_CHUNKS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .data        (data),
    .data_valid  (data_valid),
    .last        (last),
    .rx_mac      (rx_mac),
    .mac_valid   (mac_valid),
    .ready       (ready),
    .done        (done),
    .match       (match),
    .err         (err),
    .chunk_count (chunk_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic [7:0] data;
    logic       dv;
    logic       last;
    logic [7:0] rx;
    logic       mv;
    logic       e_done;
    logic       e_match;
    logic       e_err;
    logic [2:0] e_cnt;
    logic       e_ready;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] k, input logic [7:0] d, input logic dv,
                              input logic l, input logic [7:0] rx, input logic mv,
                              input logic e_done, input logic e_match, input logic e_err,
                              input logic [2:0] e_cnt, input logic e_ready, input logic e_busy);
    vec_t v;
    v.key = k; v.data = d; v.dv = dv; v.last = l; v.rx = rx; v.mv = mv;
    v.e_done = e_done; v.e_match = e_match; v.e_err = e_err;
    v.e_cnt = e_cnt; v.e_ready = e_ready; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_done, input logic e_match,
                            input logic e_err, input logic [2:0] e_cnt,
                            input logic e_ready, input logic e_busy);
    check($sformatf("%s done", tag),  32'(done),        32'(e_done));
    check($sformatf("%s match", tag), 32'(match),       32'(e_match));
    check($sformatf("%s err", tag),   32'(err),         32'(e_err));
    check($sformatf("%s count", tag), 32'(chunk_count), 32'(e_cnt));
    check($sformatf("%s ready", tag), 32'(ready),       32'(e_ready));
    check($sformatf("%s busy", tag),  32'(busy),        32'(e_busy));
  endtask

  task automatic drive(input logic [7:0] k, input logic [7:0] d, input logic dv,
                       input logic l, input logic [7:0] rx, input logic mv);
    key = k; data = d; data_valid = dv; last = l; rx_mac = rx; mac_valid = mv;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model (message level) ----------------
  // MAC over a whole message: m = k ^ c0, then m = rotl1(m) ^ k ^ ci.
  function automatic logic [7:0] mac_of(input logic [7:0] k, input logic [7:0] ch [$]);
    int m;
    m = int'(k ^ ch[0]);
    for (int i = 1; i < ch.size(); i++)
      m = (((m * 2) % 256) + (m / 128)) ^ int'(k) ^ int'(ch[i]);
    return 8'(m);
  endfunction

  logic [7:0] msg [$];      // chunks of the current/last message
  logic [7:0] cand [$];
  logic [7:0] key_m;
  bit         open_m;       // message started, last not yet seen
  bit         sealed_m;     // last seen, MAC outstanding
  logic       match_m;
  logic       ex_done, ex_err;

  task automatic model_reset();
    msg.delete();
    open_m = 0; sealed_m = 0; match_m = 0; key_m = '0;
  endtask

  // Apply one cycle of inputs to the model; sets expectations for after the edge.
  task automatic model_step();
    bit acc_ok;
    ex_done = 0; ex_err = 0;
    if (sealed_m) begin
      if (mac_valid) begin
        ex_done = 1; match_m = (rx_mac == mac_of(key_m, msg));
        sealed_m = 0;
      end
    end else begin
      acc_ok = data_valid;
      if (acc_ok) begin
        if (!open_m) begin msg.delete(); key_m = key; open_m = 1; end
        msg.push_back(data);
        if (last) begin
          open_m = 0;
          if (mac_valid) begin
            ex_done = 1; match_m = (rx_mac == mac_of(key_m, msg));
          end else sealed_m = 1;
        end else if (msg.size() == MAX_CHUNKS) begin
          ex_err = 1; open_m = 0;
        end
      end
      if (mac_valid && !(acc_ok && last)) ex_err = 1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key = '0; data = '0; data_valid = 0; last = 0; rx_mac = '0; mac_valid = 0;
    #12;
    check_outs("reset", 0, 0, 0, 3'd0, 1, 0);
    #10 rst_n = 1'b1;

    // key, data, dv, last, rx, mv | done, match, err, cnt, ready, busy
    tbl.push_back(mk(8'hFF, 8'h00, 1, 1, 8'hFF, 1,  1, 1, 0, 3'd1, 1, 0)); // single, match
    tbl.push_back(mk(8'hFF, 8'h00, 1, 1, 8'hFE, 1,  1, 0, 0, 3'd1, 1, 0)); // single, mismatch
    tbl.push_back(mk(8'hA5, 8'h3C, 1, 0, 8'h00, 0,  0, 0, 0, 3'd1, 1, 1)); // two-chunk msg
    tbl.push_back(mk(8'hA5, 8'h0F, 1, 1, 8'h00, 0,  0, 0, 0, 3'd2, 0, 1));
    tbl.push_back(mk(8'hA5, 8'h55, 1, 1, 8'h00, 0,  0, 0, 0, 3'd2, 0, 1)); // data in WAIT_MAC
    tbl.push_back(mk(8'hA5, 8'h55, 0, 0, 8'h99, 1,  1, 1, 0, 3'd2, 1, 0));
    tbl.push_back(mk(8'hA5, 8'h3C, 1, 0, 8'h00, 0,  0, 1, 0, 3'd1, 1, 1)); // key change mid-msg
    tbl.push_back(mk(8'h00, 8'h0F, 1, 1, 8'h00, 0,  0, 1, 0, 3'd2, 0, 1));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 8'h99, 1,  1, 1, 0, 3'd2, 1, 0));
    tbl.push_back(mk(8'h12, 8'h01, 1, 0, 8'h00, 0,  0, 1, 0, 3'd1, 1, 1)); // overflow
    tbl.push_back(mk(8'h12, 8'h02, 1, 0, 8'h00, 0,  0, 1, 0, 3'd2, 1, 1));
    tbl.push_back(mk(8'h12, 8'h03, 1, 0, 8'h00, 0,  0, 1, 0, 3'd3, 1, 1));
    tbl.push_back(mk(8'h12, 8'h04, 1, 0, 8'h00, 0,  0, 1, 1, 3'd4, 1, 0));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 8'h00, 1,  0, 1, 1, 3'd4, 1, 0)); // mac in IDLE
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 8'h00, 0,  0, 1, 0, 3'd4, 1, 0));
    tbl.push_back(mk(8'h03, 8'h05, 1, 0, 8'h00, 0,  0, 1, 0, 3'd1, 1, 1)); // mac in ACCUM
    tbl.push_back(mk(8'h03, 8'h00, 0, 0, 8'h08, 1,  0, 1, 1, 3'd1, 1, 1));
    tbl.push_back(mk(8'h03, 8'h07, 1, 1, 8'h08, 1,  1, 1, 0, 3'd2, 1, 0));
    tbl.push_back(mk(8'h10, 8'h20, 1, 1, 8'h30, 1,  1, 1, 0, 3'd1, 1, 0)); // back-to-back
    tbl.push_back(mk(8'h10, 8'h20, 1, 0, 8'h00, 0,  0, 1, 0, 3'd1, 1, 1));
    tbl.push_back(mk(8'h10, 8'h01, 1, 1, 8'h70, 1,  1, 0, 0, 3'd2, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].key, tbl[i].data, tbl[i].dv, tbl[i].last, tbl[i].rx, tbl[i].mv);
      check_outs($sformatf("vec%0d", i), tbl[i].e_done, tbl[i].e_match, tbl[i].e_err,
                 tbl[i].e_cnt, tbl[i].e_ready, tbl[i].e_busy);
    end

    // Async reset in the middle of a message.
    drive(8'hFF, 8'h00, 1, 1, 8'hFF, 1);
    check_outs("pre_rst match", 1, 1, 0, 3'd1, 1, 0);
    drive(8'h11, 8'h22, 1, 0, 8'h00, 0);
    check_outs("pre_rst accum", 0, 1, 0, 3'd1, 1, 1);
    #2 rst_n = 1'b0;
    #1 check_outs("mid_rst", 0, 0, 0, 3'd0, 1, 0);
    #1 rst_n = 1'b1;
    drive(8'h5A, 8'h11, 1, 0, 8'h00, 0);
    check_outs("post_rst c1", 0, 0, 0, 3'd1, 1, 1);
    drive(8'h5A, 8'h22, 1, 1, 8'hEE, 1);
    check_outs("post_rst c2", 1, 1, 0, 3'd2, 1, 0);

    // Randomized traffic against the model.
    data_valid = 0; mac_valid = 0; last = 0;
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      key        = 8'($urandom);
      data       = 8'($urandom);
      data_valid = ($urandom_range(0, 9) < 6);
      last       = ($urandom_range(0, 9) < 3);
      mac_valid  = sealed_m ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) < 2);
      rx_mac     = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (sealed_m) rx_mac = mac_of(key_m, msg);
        else if (data_valid && last) begin
          if (open_m) begin
            cand = msg; cand.push_back(data);
            rx_mac = mac_of(key_m, cand);
          end else begin
            cand.delete(); cand.push_back(data);
            rx_mac = mac_of(key, cand);
          end
        end
      end
      model_step();
      @(posedge clk);
      #1;
      check_outs($sformatf("rand%0d", cyc), ex_done, match_m, ex_err,
                 3'(msg.size()), !sealed_m, open_m || sealed_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/mac_check.md
Name: mac_check

Overview:
- Receive-side counterpart of the MAC generator.
- Consumes a message one N-bit chunk per handshake and recomputes the running MAC with the shared key.
- Compares the result against the MAC delivered with the message and reports match or mismatch.
- Sits at the decryption/receive end, gating acceptance of decrypted data.

Parameters:
N, 8, chunk, key and MAC width in bits
MAX_CHUNKS, 16, maximum chunks per message; reaching it without `last` is an error
CNT_W, $clog2(MAX_CHUNKS+1), width of chunk_count

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
key  input  N  shared MAC key; sampled on first chunk of each message
data  input  N  message chunk
data_valid  input  1  chunk present on data
last  input  1  qualifies data_valid; marks final chunk
rx_mac  input  N  MAC received with the message
mac_valid  input  1  rx_mac present
ready  output  1  block accepts chunks (IDLE or ACCUM)
done  output  1  one-cycle pulse: comparison result valid
match  output  1  1 = MACs equal; held until next done or reset
err  output  1  one-cycle pulse: protocol error or overflow
chunk_count  output  CNT_W  chunks accepted in current/last message
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, key_q=0, chunk_count=0, done=0, match=0, err=0, ready=1, busy=0.
- Per-chunk update: acc_next = rotl1(acc) ^ (k ^ data).
  - rotl1 is rotate left by 1 over N bits.
  - k = live key on the first chunk (also latched into key_q); k = key_q on later chunks.
  - key changes mid-message are ignored.
- A chunk is accepted when data_valid && ready.
- IDLE:
  - On accepted chunk: acc <= key ^ data, key_q <= key, chunk_count <= 1.
  - Next state: WAIT_MAC if last, else ACCUM.
- ACCUM:
  - On accepted chunk: acc <= acc_next, chunk_count++.
  - last -> WAIT_MAC.
  - If chunk_count reaches MAX_CHUNKS without last: err pulse next cycle, state -> IDLE, no done.
- WAIT_MAC:
  - ready=0; data_valid ignored (no err).
  - On mac_valid: match <= (rx_mac == acc), done pulse next cycle, state -> IDLE.
  - chunk_count holds until the next message's first chunk.
- Simultaneous last chunk + mac_valid (IDLE or ACCUM): compare rx_mac against the final acc value (acc_next, or key^data if single chunk). done pulses next cycle; state -> IDLE directly.
- mac_valid in IDLE or ACCUM without a simultaneous last chunk: err pulse next cycle, ignored otherwise, state unchanged.
- Latency: done/match valid 1 cycle after the accepting mac_valid edge.
- Back-to-back: a new first chunk is accepted in the cycle done is high.
- done and err are never high together.
- Width: all arithmetic is N-bit XOR/rotate; no carries.

Test Plan:
- Single chunk, N=8: key=0xFF, data=0x00, last=1, mac_valid=1 with rx_mac=0xFF the same cycle -> next cycle done=1, match=1, chunk_count=1; repeat with rx_mac=0xFE -> match=0.
- Two chunks: key=0xA5, data=0x3C, then 0x0F with last; mac_valid rx_mac=0x99 in WAIT_MAC -> acc 0x99 after chunk 1, 0x99 after chunk 2; done=1, match=1, chunk_count=2.
- Key change mid-message: same stimulus as the two-chunk case, key driven to 0x00 before the second chunk -> still match=1 with rx_mac=0x99.
- Overflow, MAX_CHUNKS=4: four chunks without last -> err pulse after 4th, state IDLE, done stays 0; mac_valid in IDLE -> err pulse.
- WAIT_MAC hold: data_valid pulses while waiting -> ready=0, acc/chunk_count unchanged, no err; later mac_valid gives the correct result.
- Async reset mid-ACCUM: rst_n low between clocks -> all outputs immediately at reset values; next message computes from acc=0 correctly.
